// File: rtl/ula_pkg.sv
// +----------------------------------------------------------------------------+
// | ula_pkg: opcode map and FSM state encoding shared by the ula_seq_param ALU  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package ula_pkg;

  localparam logic [3:0] OP_SOMA  = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_MUL   = 4'b0010;
  localparam logic [3:0] OP_QUOC  = 4'b0011;
  localparam logic [3:0] OP_RESTO = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0110;
  localparam logic [3:0] OP_OR    = 4'b0111;
  localparam logic [3:0] OP_NAND  = 4'b1000;
  localparam logic [3:0] OP_NOR   = 4'b1001;
  localparam logic [3:0] OP_XOR   = 4'b1010;
  localparam logic [3:0] OP_NOT   = 4'b1011;

  localparam logic [1:0] OCIOSO  = 2'd0;
  localparam logic [1:0] ITERA   = 2'd1;
  localparam logic [1:0] CONCLUI = 2'd2;

  function automatic logic eh_iterativo(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_QUOC) || (op == OP_RESTO);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ula_muldiv_iter.sv
// +----------------------------------------------------------------------------+
// | ula_muldiv_iter: one-bit-per-cycle shift-add multiplier / restoring divider |
// | sharing a single hi/lo shift register. Results are the post-step values.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module ula_muldiv_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic               i_modo_div,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_fim,
  output logic [2*WIDTH-1:0] o_produto,
  output logic [WIDTH-1:0]   o_quociente,
  output logic [WIDTH-1:0]   o_resto
);

  localparam int              CW    = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   c_ult = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_m;
  logic             r_div;
  logic             r_ativo;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH:0]   w_soma;
  logic [WIDTH:0]   w_desl;
  logic [WIDTH:0]   w_dif;
  logic [WIDTH-1:0] w_hi_prox;
  logic [WIDTH-1:0] w_lo_prox;

  // Multiply: r_lo holds the multiplier, product shifts right into it.
  // Divide: r_lo holds the dividend, quotient bits shift in from the right.
  always_comb begin
    w_soma    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});
    w_desl    = {r_hi, r_lo[WIDTH-1]};
    w_dif     = w_desl - {1'b0, r_m};
    w_hi_prox = w_soma[WIDTH:1];
    w_lo_prox = {w_soma[0], r_lo[WIDTH-1:1]};
    if (r_div) begin
      if (w_dif[WIDTH]) begin
        w_hi_prox = w_desl[WIDTH-1:0];
        w_lo_prox = {r_lo[WIDTH-2:0], 1'b0};
      end else begin
        w_hi_prox = w_dif[WIDTH-1:0];
        w_lo_prox = {r_lo[WIDTH-2:0], 1'b1};
      end
    end
  end

  assign o_fim       = r_ativo && (r_cnt == c_ult);
  assign o_produto   = {w_hi_prox, w_lo_prox};
  assign o_quociente = w_lo_prox;
  assign o_resto     = w_hi_prox;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi    <= '0;
      r_lo    <= '0;
      r_m     <= '0;
      r_div   <= 1'b0;
      r_ativo <= 1'b0;
      r_cnt   <= '0;
    end else if (i_start) begin
      r_hi    <= '0;
      r_lo    <= i_modo_div ? i_a : i_b;
      r_m     <= i_modo_div ? i_b : i_a;
      r_div   <= i_modo_div;
      r_ativo <= 1'b1;
      r_cnt   <= '0;
    end else if (r_ativo) begin
      r_hi  <= w_hi_prox;
      r_lo  <= w_lo_prox;
      r_cnt <= r_cnt + 1'b1;
      if (o_fim) begin
        r_ativo <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ula_seq_param.sv
// +----------------------------------------------------------------------------+
// | ula_seq_param: registered ALU with start/busy/done handshake; mul/div are  |
// | iterative. Optional Overflow port enabled by macro ULA_OVERFLOW_EN.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module ula_seq_param
  import ula_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit CMP_SIGNED = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inicio,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [3:0]         Sel_Op,
  output logic               ocupado,
  output logic               pronto,
  output logic [2*WIDTH-1:0] Resultado,
  output logic               Maior,
  output logic               Menor,
  output logic               Igual,
  output logic               Div_Zero
`ifdef ULA_OVERFLOW_EN
  ,
  output logic               Overflow
`endif
);

  logic [1:0]         r_estado;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [3:0]         r_op;
  logic [2*WIDTH-1:0] r_resultado;
  logic               r_maior;
  logic               r_menor;
  logic               r_igual;
  logic               r_div_zero;

  logic               w_ocioso;
  logic               w_itera;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic               w_maior;
  logic               w_menor;
  logic               w_igual;
  logic [WIDTH:0]     w_soma;
  logic [WIDTH:0]     w_dif;
  logic [2*WIDTH-1:0] w_res_simples;
  logic [2*WIDTH-1:0] w_res_iter;
  logic               w_dz;
  logic               w_fim;
  logic [2*WIDTH-1:0] w_produto;
  logic [WIDTH-1:0]   w_quociente;
  logic [WIDTH-1:0]   w_resto;

  assign w_ocioso = (r_estado == OCIOSO);
  assign w_itera  = eh_iterativo(Sel_Op) && (B != '0);

  // Flags are registered on the same edge as the result: on acceptance for
  // single-cycle ops (operands still on the ports), on the last step otherwise.
  assign w_a     = w_ocioso ? A : r_a;
  assign w_b     = w_ocioso ? B : r_b;
  assign w_igual = (w_a == w_b);

  generate
    if (CMP_SIGNED) begin : g_cmp_signed
      assign w_maior = $signed(w_a) > $signed(w_b);
      assign w_menor = $signed(w_a) < $signed(w_b);
    end else begin : g_cmp_unsigned
      assign w_maior = w_a > w_b;
      assign w_menor = w_a < w_b;
    end
  endgenerate

  assign w_soma = {1'b0, A} + {1'b0, B};
  assign w_dif  = {1'b0, A} - {1'b0, B};

  always_comb begin
    w_res_simples = '0;
    w_dz          = 1'b0;
    case (Sel_Op)
      OP_SOMA:  w_res_simples = {{(WIDTH-1){1'b0}}, w_soma};
      OP_SUB:   w_res_simples = {{(WIDTH-1){1'b0}}, w_dif};
      OP_QUOC: begin
        w_res_simples = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
        w_dz          = (B == '0);
      end
      OP_RESTO: begin
        w_res_simples = {{WIDTH{1'b0}}, A};
        w_dz          = (B == '0);
      end
      OP_AND:   w_res_simples = {{WIDTH{1'b0}}, A & B};
      OP_OR:    w_res_simples = {{WIDTH{1'b0}}, A | B};
      OP_NAND:  w_res_simples = {{WIDTH{1'b0}}, ~(A & B)};
      OP_NOR:   w_res_simples = {{WIDTH{1'b0}}, ~(A | B)};
      OP_XOR:   w_res_simples = {{WIDTH{1'b0}}, A ^ B};
      OP_NOT:   w_res_simples = {{WIDTH{1'b0}}, ~A};
      default:  w_res_simples = '0;
    endcase
  end

`ifdef ULA_OVERFLOW_EN
  logic r_ov;
  logic w_ov;

  always_comb begin
    w_ov = 1'b0;
    if (Sel_Op == OP_SOMA) begin
      w_ov = (A[WIDTH-1] == B[WIDTH-1]) && (w_soma[WIDTH-1] != A[WIDTH-1]);
    end else if (Sel_Op == OP_SUB) begin
      w_ov = (A[WIDTH-1] != B[WIDTH-1]) && (w_dif[WIDTH-1] != A[WIDTH-1]);
    end
  end

  assign Overflow = r_ov;
`endif

  ula_muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_ocioso && inicio && w_itera),
    .i_modo_div (Sel_Op != OP_MUL),
    .i_a        (A),
    .i_b        (B),
    .o_fim      (w_fim),
    .o_produto  (w_produto),
    .o_quociente(w_quociente),
    .o_resto    (w_resto)
  );

  always_comb begin
    w_res_iter = w_produto;
    if (r_op == OP_QUOC) begin
      w_res_iter = {{WIDTH{1'b0}}, w_quociente};
    end else if (r_op == OP_RESTO) begin
      w_res_iter = {{WIDTH{1'b0}}, w_resto};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado    <= OCIOSO;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_resultado <= '0;
      r_maior     <= 1'b0;
      r_menor     <= 1'b0;
      r_igual     <= 1'b0;
      r_div_zero  <= 1'b0;
`ifdef ULA_OVERFLOW_EN
      r_ov        <= 1'b0;
`endif
    end else begin
      case (r_estado)
        OCIOSO: begin
          if (inicio) begin
            r_a  <= A;
            r_b  <= B;
            r_op <= Sel_Op;
            if (w_itera) begin
              r_estado <= ITERA;
            end else begin
              r_estado    <= CONCLUI;
              r_resultado <= w_res_simples;
              r_maior     <= w_maior;
              r_menor     <= w_menor;
              r_igual     <= w_igual;
              r_div_zero  <= w_dz;
`ifdef ULA_OVERFLOW_EN
              r_ov        <= w_ov;
`endif
            end
          end
        end
        ITERA: begin
          if (w_fim) begin
            r_estado    <= CONCLUI;
            r_resultado <= w_res_iter;
            r_maior     <= w_maior;
            r_menor     <= w_menor;
            r_igual     <= w_igual;
            r_div_zero  <= 1'b0;
`ifdef ULA_OVERFLOW_EN
            r_ov        <= 1'b0;
`endif
          end
        end
        CONCLUI: r_estado <= OCIOSO;
        default: r_estado <= OCIOSO;
      endcase
    end
  end

  assign ocupado   = !w_ocioso;
  assign pronto    = (r_estado == CONCLUI);
  assign Resultado = r_resultado;
  assign Maior     = r_maior;
  assign Menor     = r_menor;
  assign Igual     = r_igual;
  assign Div_Zero  = r_div_zero;

endmodule

`default_nettype wire

// File: tb/tb_ula_seq_param.sv
// +----------------------------------------------------------------------------+
// | tb_ula_seq_param: self-checking bench for ula_seq_param (WIDTH=8), with an |
// | unsigned-compare and a signed-compare instance driven in parallel.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ula_seq_param;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        inicio = 1'b0;
  logic [7:0]  A      = '0;
  logic [7:0]  B      = '0;
  logic [3:0]  Sel_Op = '0;

  logic        ocupado, pronto, Maior, Menor, Igual, Div_Zero;
  logic [15:0] Resultado;
  logic        ocupado_s, pronto_s, maior_s, menor_s, igual_s, dz_s;
  logic [15:0] res_s;
`ifdef ULA_OVERFLOW_EN
  logic        Overflow, ov_s;
`endif

  always #5 clk = ~clk;

  ula_seq_param #(.WIDTH(8), .CMP_SIGNED(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .inicio(inicio), .A(A), .B(B), .Sel_Op(Sel_Op),
    .ocupado(ocupado), .pronto(pronto), .Resultado(Resultado),
    .Maior(Maior), .Menor(Menor), .Igual(Igual), .Div_Zero(Div_Zero)
`ifdef ULA_OVERFLOW_EN
    , .Overflow(Overflow)
`endif
  );

  ula_seq_param #(.WIDTH(8), .CMP_SIGNED(1'b1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .inicio(inicio), .A(A), .B(B), .Sel_Op(Sel_Op),
    .ocupado(ocupado_s), .pronto(pronto_s), .Resultado(res_s),
    .Maior(maior_s), .Menor(menor_s), .Igual(igual_s), .Div_Zero(dz_s)
`ifdef ULA_OVERFLOW_EN
    , .Overflow(ov_s)
`endif
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  op;
    logic [15:0] res;
    logic [2:0]  flags;  // {Maior, Menor, Igual}
    logic        dz;
    int          lat;
  } vec_t;

  vec_t tab[12];

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] c_res;
  logic [2:0]  c_flags, c_flags_s;
  logic        c_dz, c_ov;
  int          c_lat;

  task automatic verifica(input string nome, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", nome, got, exp);
    end
  endtask

  // Issue one op and wait (bounded) for pronto; latency counted from the inicio edge.
  task automatic executa(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    @(negedge clk);
    A = a; B = b; Sel_Op = op; inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    c_lat  = -1;
    for (int k = 1; k <= 40; k++) begin
      if (pronto) begin
        c_lat = k;
        break;
      end
      @(negedge clk);
    end
    c_res     = Resultado;
    c_flags   = {Maior, Menor, Igual};
    c_flags_s = {maior_s, menor_s, igual_s};
    c_dz      = Div_Zero;
`ifdef ULA_OVERFLOW_EN
    c_ov      = Overflow;
`else
    c_ov      = 1'b0;
`endif
  endtask

  function automatic void modelo(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                                 output logic [15:0] res, output logic dz, output int lat,
                                 output logic ov, output logic [2:0] fl, output logic [2:0] fl_s);
    int ia, ib, sa, sb;
    ia = int'(a); ib = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    res = 16'd0; dz = 1'b0; lat = 1; ov = 1'b0;
    case (op)
      4'd0: begin res = 16'(ia + ib); ov = (sa + sb > 127) || (sa + sb < -128); end
      4'd1: begin res = 16'((ia - ib + 256) % 256 + ((ia < ib) ? 256 : 0)); ov = (sa - sb > 127) || (sa - sb < -128); end
      4'd2: begin res = 16'(ia * ib); lat = (ib != 0) ? 9 : 1; end
      4'd3: if (ib == 0) begin res = 16'd255; dz = 1'b1; end else begin res = 16'(ia / ib); lat = 9; end
      4'd4: if (ib == 0) begin res = 16'(ia); dz = 1'b1; end else begin res = 16'(ia % ib); lat = 9; end
      4'd6: res = {8'h00, a & b};
      4'd7: res = {8'h00, a | b};
      4'd8: res = {8'h00, ~(a & b)};
      4'd9: res = {8'h00, ~(a | b)};
      4'd10: res = {8'h00, a ^ b};
      4'd11: res = {8'h00, ~a};
      default: res = 16'd0;
    endcase
    fl   = {ia > ib, ia < ib, ia == ib};
    fl_s = {sa > sb, sa < sb, sa == sb};
  endfunction

  initial begin
    logic [15:0] e_res;
    logic        e_dz, e_ov, visto;
    logic [2:0]  e_fl, e_fl_s;
    int          e_lat;
    logic [7:0]  ra, rb;
    logic [3:0]  rop;

    tab[0]  = '{8'd50,  8'd30,  4'b0000, 16'd80,    3'b100, 1'b0, 1};
    tab[1]  = '{8'd100, 8'd5,   4'b0011, 16'd20,    3'b100, 1'b0, 9};
    tab[2]  = '{8'd23,  8'd5,   4'b0100, 16'd3,     3'b100, 1'b0, 9};
    tab[3]  = '{8'd7,   8'd0,   4'b0011, 16'h00FF,  3'b100, 1'b1, 1};
    tab[4]  = '{8'd7,   8'd0,   4'b0100, 16'd7,     3'b100, 1'b1, 1};
    tab[5]  = '{8'hF0,  8'hAA,  4'b1000, 16'h005F,  3'b100, 1'b0, 1};
    tab[6]  = '{8'hF0,  8'hAA,  4'b1011, 16'h000F,  3'b100, 1'b0, 1};
    tab[7]  = '{8'hF0,  8'hAA,  4'b1100, 16'h0000,  3'b100, 1'b0, 1};
    tab[8]  = '{8'd20,  8'd20,  4'b0010, 16'd400,   3'b001, 1'b0, 9};
    tab[9]  = '{8'd10,  8'd20,  4'b0001, 16'h01F6,  3'b010, 1'b0, 1};
    tab[10] = '{8'd200, 8'd100, 4'b0000, 16'h012C,  3'b100, 1'b0, 1};
    tab[11] = '{8'd255, 8'd255, 4'b0010, 16'hFE01,  3'b001, 1'b0, 9};

    repeat (2) @(negedge clk);
    verifica("rst_ocupado", ocupado, 0);
    verifica("rst_pronto", pronto, 0);
    verifica("rst_resultado", Resultado, 0);
    verifica("rst_flags", {Maior, Menor, Igual}, 0);
    verifica("rst_div_zero", Div_Zero, 0);
    rst_n = 1'b1;

    foreach (tab[i]) begin
      executa(tab[i].a, tab[i].b, tab[i].op);
      verifica($sformatf("tab%0d_res", i), c_res, tab[i].res);
      verifica($sformatf("tab%0d_flags", i), c_flags, tab[i].flags);
      verifica($sformatf("tab%0d_dz", i), c_dz, tab[i].dz);
      verifica($sformatf("tab%0d_lat", i), c_lat, tab[i].lat);
    end

    executa(8'hF0, 8'h10, 4'b0000);
    verifica("cmp_unsigned_F0_10", c_flags, 3'b100);
    verifica("cmp_signed_F0_10", c_flags_s, 3'b010);

    // Multiply with an extra inicio in cycle 4 that must be dropped.
    @(negedge clk);
    A = 8'd20; B = 8'd20; Sel_Op = 4'b0010; inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      verifica($sformatf("t2_ocupado_c%0d", k), ocupado, (k <= 9));
      verifica($sformatf("t2_pronto_c%0d", k), pronto, (k == 9));
      if (k == 9) begin
        verifica("t2_res", Resultado, 16'd400);
        verifica("t2_igual", Igual, 1);
      end
      inicio = (k == 4);
      if (k == 4) begin
        A = 8'd1; B = 8'd1; Sel_Op = 4'b0000;
      end
      @(negedge clk);
    end

    for (int n = 0; n < 300; n++) begin
      ra  = 8'($urandom);
      rop = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 7))
        0: rb = 8'd0;
        1: rb = ra;
        default: rb = 8'($urandom);
      endcase
      executa(ra, rb, rop);
      modelo(ra, rb, rop, e_res, e_dz, e_lat, e_ov, e_fl, e_fl_s);
      verifica($sformatf("rnd%0d_op%0h_res", n, rop), c_res, e_res);
      verifica($sformatf("rnd%0d_flags", n), c_flags, e_fl);
      verifica($sformatf("rnd%0d_flags_s", n), c_flags_s, e_fl_s);
      verifica($sformatf("rnd%0d_dz", n), c_dz, e_dz);
      verifica($sformatf("rnd%0d_lat", n), c_lat, e_lat);
`ifdef ULA_OVERFLOW_EN
      verifica($sformatf("rnd%0d_ov", n), c_ov, e_ov);
`endif
    end

    // Reset in the middle of a multiply: outputs drop at once, no pronto follows.
    executa(8'd100, 8'd5, 4'b0011);
    verifica("t6_pre_res", c_res, 16'd20);
    @(negedge clk);
    A = 8'd200; B = 8'd3; Sel_Op = 4'b0010; inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    verifica("t6_ocupado", ocupado, 0);
    verifica("t6_pronto", pronto, 0);
    verifica("t6_res", Resultado, 0);
    verifica("t6_flags", {Maior, Menor, Igual}, 0);
    verifica("t6_dz", Div_Zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    visto = 1'b0;
    repeat (12) begin
      @(negedge clk);
      visto = visto | pronto | ocupado;
    end
    verifica("t6_sem_pronto", visto, 0);
    executa(8'd100, 8'd100, 4'b0000);
    verifica("t6_pos_res", c_res, 16'd200);
    verifica("t6_pos_lat", c_lat, 1);
`ifdef ULA_OVERFLOW_EN
    verifica("t6_pos_ov", c_ov, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
